// File: rtl/char_normalizer.sv
// ============================================================================
// char_normalizer: folds case, collapses blank runs, drops illegal bytes, FIFO.
// Optional macro WS_CONTROL_AS_BLANK_EN treats tab/LF/CR as blank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module char_normalizer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               err_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_WORD  = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    logic             full;
    logic             empty;
    logic             is_blank;
    logic             is_nul;
    logic             is_upper;
    logic             is_print;
    logic             is_illegal;
    logic             accept;
    logic             push;
    logic             pop;
    logic [7:0]       push_data;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign in_ready  = !full;
    assign out_valid = !empty;
    // Masked while empty so the head reads 0x00 after reset regardless of memory contents.
    assign out_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
    assign count     = wr_ptr - rd_ptr;

`ifdef WS_CONTROL_AS_BLANK_EN
    assign is_blank = (in_data == 8'h20) || (in_data == 8'h09) ||
                      (in_data == 8'h0A) || (in_data == 8'h0D);
`else
    assign is_blank = (in_data == 8'h20);
`endif
    assign is_nul     = (in_data == 8'h00);
    assign is_upper   = (in_data >= 8'h41) && (in_data <= 8'h5A);
    assign is_print   = (in_data >= 8'h21) && (in_data <= 8'h7E);
    assign is_illegal = !(is_blank || is_nul || is_print);

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        push      = 1'b0;
        push_data = in_data;
        if (accept) begin
            if (is_nul) begin
                push      = 1'b1;
                push_data = 8'h00;
            end else if (is_blank) begin
                // Only the first blank after a word survives; later blanks collapse into it.
                push      = (state == S_WORD);
                push_data = 8'h20;
            end else if (is_print) begin
                push      = 1'b1;
                push_data = is_upper ? (in_data + 8'h20) : in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            err_cnt <= 8'h00;
            state   <= S_START;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && is_illegal && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'h01;
            end
            if (accept && !is_illegal) begin
                if (is_nul) begin
                    state <= S_START;
                end else if (is_blank) begin
                    if (state == S_WORD) begin
                        state <= S_GAP;
                    end
                end else begin
                    state <= S_WORD;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_char_normalizer.sv
// ============================================================================
// tb_char_normalizer: directed vectors, expected bytes queued, monitor compares.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_char_normalizer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] count;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_err = 0;
    logic [7:0] exp_q [$];

    char_normalizer #(.DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every handshake on the output side pops one expected byte.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got 0x%0h expected none", out_data);
            end else begin
                chk("out_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready 0 expected 1");
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic expect_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && t < 100) begin
            tick();
            t++;
        end
        chk({name, "_left"}, exp_q.size(), 0);
        chk({name, "_count"}, int'(count), 0);
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_count", int'(count), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);

        // Leading blanks dropped, run collapsed, case folded; trailing " z" proves S_WORD.
        out_ready = 1'b1;
        expect_str("begin end z");
        exp_q.push_back(8'h00);
        send_str("  Begin  END");
        send_str(" z");
        send(8'h00);
        drain("basic");
        chk("basic_err", int'(err_cnt), 0);

        // Fill to full, verify back-pressure holds even when out_ready rises.
        out_ready = 1'b0;
        expect_str("abcdefghij");
        send_str("abcdefgh");
        chk("full_count", int'(count), 8);
        chk("full_in_ready", int'(in_ready), 0);
        in_data  = "i";
        in_valid = 1'b1;
        tick();
        tick();
        chk("full_hold_count", int'(count), 8);
        out_ready = 1'b1;
        chk("full_ready_pop", int'(in_ready), 0);
        send("i");
        send("j");
        drain("full");
        chk("full_out_valid", int'(out_valid), 0);

        // Blank after nul is dropped.
        exp_q.push_back("a");
        exp_q.push_back(8'h00);
        exp_q.push_back("b");
        send("a");
        send(8'h00);
        send(" ");
        send("b");
        drain("nul");

        exp_q.push_back("x");
`ifdef WS_CONTROL_AS_BLANK_EN
        exp_q.push_back(8'h20);
`else
        exp_err++;
`endif
        exp_q.push_back("y");
        send("x");
        send(8'h09);
        send("y");
        drain("tab");
        chk("tab_err", int'(err_cnt), exp_err);

        for (int i = 0; i < 300; i++) send(8'h80);
        drain("illegal");
        chk("illegal_err_sat", int'(err_cnt), 255);
        chk("illegal_no_out", int'(out_valid), 0);

        // Reset mid-stream discards buffered bytes.
        out_ready = 1'b0;
        send_str("12345");
        chk("pre_rst_count", int'(count), 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_err", int'(err_cnt), 0);
        exp_q.push_back("q");
        send("Q");
        chk("lat_valid", int'(out_valid), 1);
        chk("lat_data", int'(out_data), 8'h71);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
